// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: RV32I ops in one cycle, RV32M multiply (shift-add) and
// divide (restoring) iteratively, result registered behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            op5,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic [XLEN-1:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d, mcand_q, mcand_d;
    logic              neg_q, neg_d, hi_sel_q, hi_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    op_e               op;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   alu_res, mag_a, mag_b, spec_res;
    logic              is_mul, is_div, sgn_a, sgn_b, want_hi, a_neg, b_neg, div0, ovf, accept;

    always_comb begin
        op = OP_ADD;
        if (ALUOp == 2'b01) begin
            op = OP_SUB;
        end else if (ALUOp == 2'b10) begin
            if (op5 && funct7_0) begin
                case (funct3)
                    3'b000:  op = OP_MUL;
                    3'b001:  op = OP_MULH;
                    3'b010:  op = OP_MULHSU;
                    3'b011:  op = OP_MULHU;
                    3'b100:  op = OP_DIV;
                    3'b101:  op = OP_DIVU;
                    3'b110:  op = OP_REM;
                    default: op = OP_REMU;
                endcase
            end else begin
                case (funct3)
                    3'b000:  op = (op5 && funct7_5) ? OP_SUB : OP_ADD;
                    3'b001:  op = OP_SLL;
                    3'b010:  op = OP_SLT;
                    3'b011:  op = OP_SLTU;
                    3'b100:  op = OP_XOR;
                    3'b101:  op = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110:  op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
        end
    end

    assign shamt = src_b[SH_W-1:0];

    always_comb begin
        case (op)
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            OP_OR:   alu_res = src_a | src_b;
            OP_AND:  alu_res = src_a & src_b;
            default: alu_res = src_a + src_b;
        endcase
    end

    assign is_mul  = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div  = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign sgn_a   = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign sgn_b   = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign want_hi = op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    assign a_neg   = sgn_a & src_a[XLEN-1];
    assign b_neg   = sgn_b & src_b[XLEN-1];
    assign mag_a   = a_neg ? -src_a : src_a;
    assign mag_b   = b_neg ? -src_b : src_b;
    assign div0    = (src_b == '0);
    assign ovf     = sgn_b && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    assign spec_res = div0 ? (want_hi ? src_a : '1) : (want_hi ? '0 : src_a);

    // One iteration step; p_hi/p_lo hold {partial product, multiplier} or {remainder, quotient}.
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_shift, mul_fix;
    logic [XLEN-1:0]   it_hi, it_lo, div_pick, div_fix, fin_res;

    assign mul_sum   = p_lo_q[0] ? ({1'b0, p_hi_q} + {1'b0, mcand_q}) : {1'b0, p_hi_q};
    assign mul_shift = {mul_sum, p_lo_q[XLEN-1:1]};
    assign div_sh    = {p_hi_q, p_lo_q[XLEN-1]};
    assign div_diff  = div_sh - {1'b0, mcand_q};

    always_comb begin
        if (state_q == S_MUL) begin
            it_hi = mul_shift[2*XLEN-1:XLEN];
            it_lo = mul_shift[XLEN-1:0];
        end else if (!div_diff[XLEN]) begin
            it_hi = div_diff[XLEN-1:0];
            it_lo = {p_lo_q[XLEN-2:0], 1'b1};
        end else begin
            it_hi = div_sh[XLEN-1:0];
            it_lo = {p_lo_q[XLEN-2:0], 1'b0};
        end
    end

    assign mul_fix  = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    assign div_pick = hi_sel_q ? it_hi : it_lo;
    assign div_fix  = neg_q ? -div_pick : div_pick;
    assign fin_res  = (state_q == S_MUL)
                    ? (hi_sel_q ? mul_fix[2*XLEN-1:XLEN] : mul_fix[XLEN-1:0]) : div_fix;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign result    = result_q;
    assign zero      = zero_q;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        hi_sel_d = hi_sel_q;
        cnt_d    = cnt_q;
        if (busy) begin
            p_hi_d = it_hi;
            p_lo_d = it_lo;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
                state_d  = S_DONE;
                result_d = fin_res;
                zero_d   = (fin_res == '0);
            end
        end else if (accept) begin
            hi_sel_d = want_hi;
            cnt_d    = '0;
            p_hi_d   = '0;
            if (is_mul) begin
                state_d = S_MUL;
                mcand_d = mag_a;
                p_lo_d  = mag_b;
                neg_d   = a_neg ^ b_neg;
            end else if (is_div && !div0 && !ovf) begin
                state_d = S_DIV;
                mcand_d = mag_b;
                p_lo_d  = mag_a;
                neg_d   = want_hi ? a_neg : (a_neg ^ b_neg);
            end else begin
                state_d  = S_DONE;
                result_d = is_div ? spec_res : alu_res;
                zero_d   = ((is_div ? spec_res : alu_res) == '0);
            end
        end else if (state_q == S_DONE && out_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            hi_sel_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            hi_sel_q <= hi_sel_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a 32-bit instance for the full op set and
// handshake behaviour, plus an 8-bit instance for width-dependent behaviour.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, op5, funct7_5, funct7_0;
    logic        out_valid, out_ready, zero, busy;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b, result;

    logic        e_in_valid, e_in_ready, e_op5, e_funct7_5, e_funct7_0;
    logic        e_out_valid, e_out_ready, e_zero, e_busy;
    logic [1:0]  e_ALUOp;
    logic [2:0]  e_funct3;
    logic [7:0]  e_src_a, e_src_b, e_result;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_unit #(.XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct3(funct3), .op5(op5), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    alu_exec_unit #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .ALUOp(e_ALUOp), .funct3(e_funct3), .op5(e_op5), .funct7_5(e_funct7_5),
        .funct7_0(e_funct7_0), .src_a(e_src_a), .src_b(e_src_b), .out_valid(e_out_valid),
        .out_ready(e_out_ready), .result(e_result), .zero(e_zero), .busy(e_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic o5,
                          input logic f75, input logic f70, input logic [31:0] a,
                          input logic [31:0] b);
        ALUOp = aop; funct3 = f3; op5 = o5; funct7_5 = f75; funct7_0 = f70;
        src_a = a; src_b = b; in_valid = 1'b1;
    endtask

    // Single-cycle op with out_ready high: accepted at this edge, result visible right after.
    task automatic single(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic o5, input logic f75, input logic f70,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_op(aop, f3, o5, f75, f70, a, b);
        out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    endtask

    // M-extension op; lat = edges between accept and out_valid rising (== busy cycles).
    task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        int nb;
        set_op(2'b10, f3, 1'b1, 1'b0, 1'b1, a, b);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        nb = 0;
        while (!out_valid && cyc < 80) begin
            if (busy) nb++;
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(lat));
        chk({tag, "_busy"}, 32'(nb), 32'(lat));
        chk({tag, "_res"}, result, exp);
        tick();
    endtask

    initial begin
        int seen;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        in_valid = 1'b0;
        e_in_valid = 1'b0; e_out_ready = 1'b1; e_ALUOp = 2'b00; e_funct3 = 3'b000;
        e_op5 = 1'b0; e_funct7_5 = 1'b0; e_funct7_0 = 1'b0; e_src_a = 8'd0; e_src_b = 8'd0;
        tick(); tick();
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // back-to-back single-cycle ops
        single("sub_r",  2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE);
        single("sra",    2'b10, 3'b101, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h24, 32'hF800_0000);
        single("sltu",   2'b10, 3'b011, 1'b1, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1);
        single("sub_op", 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0);
        single("addi",   2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12);
        single("addi_m", 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 32'd3, 32'd4, 32'd7);
        single("slt",    2'b10, 3'b010, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single("srl",    2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000);
        single("sll",    2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 32'd1, 32'd33, 32'd2);
        single("xor",    2'b10, 3'b100, 1'b1, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        single("or",     2'b10, 3'b110, 1'b1, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        single("and",    2'b10, 3'b111, 1'b1, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030);
        single("add11",  2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5);
        in_valid = 1'b0;
        tick();
        chk("idle_vld", 32'(out_valid), 32'd0);

        run_m("mulh",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32);
        run_m("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        run_m("mul",   3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32);
        run_m("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32);
        run_m("div",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run_m("rem",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run_m("divu",  3'b101, 32'd100, 32'd7, 32'd14, 32);
        run_m("remu",  3'b111, 32'd100, 32'd7, 32'd2, 32);
        run_m("divu0", 3'b101, 32'd123, 32'd0, 32'hFFFF_FFFF, 0);
        run_m("remu0", 3'b111, 32'd123, 32'd0, 32'd123, 0);
        run_m("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        chk("removf_zero", 32'(zero), 32'd1);
        run_m("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);

        // backpressure: result must hold while out_ready is low
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
        out_ready = 1'b0;
        tick();
        chk("bp_vld", 32'(out_valid), 32'd1);
        chk("bp_res", result, 32'd3);
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", 32'(in_ready), 32'd0);
            tick();
            chk("bp_hold", result, 32'd3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next", result, 32'd30);
        in_valid = 1'b0;
        tick();

        // reset in the middle of an iterative divide
        set_op(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
        tick();
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd4, 32'd4);
        for (int i = 0; i < 5; i++) tick();
        chk("busy_rdy", 32'(in_ready), 32'd0);
        chk("busy_on", 32'(busy), 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_vld", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_res", result, 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mrst_stale", 32'(seen), 32'd0);

        // 8-bit build: MULHU and shift-amount masking
        e_ALUOp = 2'b10; e_funct3 = 3'b011; e_op5 = 1'b1; e_funct7_0 = 1'b1; e_funct7_5 = 1'b0;
        e_src_a = 8'hFF; e_src_b = 8'hFF; e_in_valid = 1'b1;
        tick();
        e_in_valid = 1'b0;
        cyc = 0;
        while (!e_out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("x8_mulhu_lat", 32'(cyc), 32'd8);
        chk("x8_mulhu_res", 32'(e_result), 32'h0000_00FE);
        tick();
        e_funct3 = 3'b001; e_funct7_0 = 1'b0; e_src_a = 8'd1; e_src_b = 8'd9; e_in_valid = 1'b1;
        tick();
        e_in_valid = 1'b0;
        chk("x8_sll_vld", 32'(e_out_valid), 32'd1);
        chk("x8_sll_res", 32'(e_result), 32'd2);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit extending the ALU decode path from a fixed 3-bit single-cycle control to full RV32I ALU operations plus the RV32M multiply/divide group. It decodes ALUOp/funct3/op5/funct7 internally, runs logic and arithmetic ops in one cycle and MUL/DIV iteratively, and presents a registered result through a valid/ready handshake. It sits between the register-file read and the writeback mux, and lets the core move to a multi-cycle execute stage.

## Interface

- XLEN, 32: operand/result width; power of two, 8..64.
- CNT_W, $clog2(XLEN)+1: internal iteration counter width; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit accepts an operation this cycle.
- ALUOp  input  2  00 add, 01 subtract, 10 funct-decoded, 11 treated as add.
- funct3  input  3  instruction funct3.
- op5  input  1  opcode bit 5 (1 = R-type).
- funct7_5  input  1  funct7 bit 5 (SUB/SRA select).
- funct7_0  input  1  funct7 bit 0 (M-extension select).
- src_a, src_b  input  XLEN  operands.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  registered result.
- zero  output  1  result == 0, registered with result.
- busy  output  1  MUL/DIV iteration in progress.

## Operation

- Accept when in_valid && in_ready; operands and decoded op captured.
- ALUOp 00/11 -> ADD; 01 -> SUB.
- ALUOp 10, funct7_0=0: funct3 000 ADD (SUB if op5 && funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7_5), 110 OR, 111 AND. funct7_5 ignored for ADD when op5=0 (ADDI).
- ALUOp 10, op5=1, funct7_0=1: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. funct7_0 ignored when op5=0.
- Shift amount = src_b[$clog2(XLEN)-1:0]; SRA sign-fills.
- MUL returns low XLEN bits of 2*XLEN product; MULH/MULHSU/MULHU return high XLEN bits, signedness per RISC-V.
- Multiply: radix-2 shift-add on operand magnitudes, sign fix-up at end. Divide: restoring, 1 quotient bit per cycle on magnitudes; quotient negated if signs differ, remainder takes dividend sign.
- Divide by zero: quotient all ones, remainder = src_a, no iteration.
- Signed overflow (src_a = most-negative, src_b = -1, DIV/REM): quotient = src_a, remainder 0, no iteration.
- FSM: IDLE -> (single-cycle op or div special case) DONE; IDLE -> MUL / DIV on accept; MUL/DIV -> DONE after XLEN iterations; DONE -> IDLE on out_ready (or directly to next op if in_valid accepted the same cycle).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- out_valid = (state==DONE); result/zero stable while out_valid && !out_ready.
- busy = state is MUL or DIV.

## Timing

- Reset (rst_n low at a clock edge): state IDLE, out_valid 0, result 0, zero 0, busy 0, in_ready 1 the following cycle; any in-flight MUL/DIV aborted, no result produced.
- Single-cycle op accepted at edge T: out_valid, result at T+1.
- MUL family / DIV family (non-special): busy T+1..T+XLEN, out_valid at T+XLEN+1 (T+33 for XLEN=32).
- Divide special cases: out_valid at T+1.
- Back-to-back: with out_ready held high, a new single-cycle op is accepted every cycle (throughput 1/cycle).
- in_valid during busy is not accepted; inputs may change freely while in_ready=0.
- Output is held indefinitely under out_ready=0; no result is lost or overwritten.

## Test plan

- Reset mid-DIV: start DIVU 100/7, drop rst_n at iteration 10 -> next cycle out_valid=0, busy=0, result=0, in_ready=1; no stale result appears later.
- ALU sweep, out_ready=1: ALUOp=10, op5=1, funct7_5=1, funct3=000, a=5, b=7 -> result 0xFFFFFFFE, zero=0, one cycle later; SRA a=0x80000000, b=0x24 -> 0xF8000000; SLTU a=1, b=0xFFFFFFFF -> 1; ALUOp=01, a=b=9 -> zero=1.
- Multiply: MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MUL a=-3, b=7 -> 0xFFFFFFEB; each out_valid exactly 33 cycles after accept, busy high 32 cycles.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU by 0 -> 0xFFFFFFFF at T+1; REM 0x80000000/-1 -> 0 at T+1.
- Backpressure: single-cycle ADD 1+2 with out_ready=0 for 5 cycles while in_valid stays high -> in_ready=0, result holds 3, next op accepted only in the cycle out_ready=1.
- XLEN=8 build: MULHU 0xFF*0xFF -> 0xFE after 9 cycles; shift amount uses src_b[2:0] only (SLL 1 by 9 -> 2).
